// File: rtl/letter_entry_encoder.sv
// Button-driven letter selector with debounce, wrap-around stepping and a
// valid/ready commit path. Optional auto-repeat: define LETTER_AUTOREPEAT_EN.
module letter_entry_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SYMBOLS     = 26,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    output logic [4:0] cur_letter,
    output logic [4:0] out_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] LAST_SYM = 5'(NUM_SYMBOLS - 1);

    // Reject configurations the counters and 5-bit codes cannot represent
    if (DEBOUNCE_CYCLES < 2 || NUM_SYMBOLS < 1 || NUM_SYMBOLS > 32 ||
        REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("letter_entry_encoder: illegal parameter set");
    end

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    // Bit order in the button vectors: [0]=up, [1]=down, [2]=enter
    logic [2:0] raw;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] stable_q, stable_d;
    logic [2:0] press_q, press_d;
    logic [CW-1:0] db_cnt_q [3];
    logic [CW-1:0] db_cnt_d [3];

    logic [1:0] step;
    logic       enter;

    state_t     state_q, state_d;
    logic [4:0] cur_q, cur_d;
    logic [4:0] ol_q, ol_d;
    logic       ovf_q, ovf_d;

    assign raw = {btn_enter, btn_down, btn_up};

    // Synchronise, debounce and detect stable rising levels
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
        press_d = stable_d & ~stable_q;
    end

    // Input conditioning registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

`ifdef LETTER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];
    logic [1:0]    rep_fire;

    // Repeat timers for up/down, running while the stable level is held
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_fire[i]  = 1'b0;
            rep_cnt_d[i] = '0;
            if (stable_q[i]) begin
                if (rep_cnt_q[i] == RP_LAST) begin
                    rep_fire[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
                end
            end
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
        end
    end

    assign step = press_q[1:0] | rep_fire;
`else
    assign step = press_q[1:0];
`endif

    assign enter = press_q[2];

    // Letter stepping and commit FSM next-state
    always_comb begin
        cur_d   = cur_q;
        state_d = state_q;
        ol_d    = ol_q;
        ovf_d   = 1'b0;

        if (step[0] && !step[1]) begin
            cur_d = (cur_q == LAST_SYM) ? 5'd0 : cur_q + 5'd1;
        end else if (step[1] && !step[0]) begin
            cur_d = (cur_q == 5'd0) ? LAST_SYM : cur_q - 5'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (enter) begin
                    ol_d    = cur_q;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (out_ready) begin
                    if (enter) begin
                        ol_d = cur_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (enter) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Selection and commit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 5'd0;
            ol_q    <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ol_q    <= ol_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cur_letter = cur_q;
    assign out_letter = ol_q;
    assign out_valid  = (state_q == PEND);
    assign overflow   = ovf_q;

endmodule
